// File: rtl/wb_commit_unit.sv
// rtl/wb_commit_unit.sv - write-back/commit stage with variable-latency load wait
module wb_commit_unit #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 4,
    parameter int LD_SRC  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          w_valid,
    output logic                          w_ready,
    input  logic                          w_flush,
    input  logic                          w_reg_write,
    input  logic [4:0]                    w_rd,
    input  logic [$clog2(NUM_SRC)-1:0]    w_wb_sel,
    input  logic [2:0]                    w_funct3,
    input  logic [$clog2(XLEN/8)-1:0]     w_addr_lo,
    input  logic [NUM_SRC*XLEN-1:0]       w_src_data,
    input  logic                          ld_rvalid,
    input  logic [XLEN-1:0]               ld_rdata,
    output logic                          rf_we,
    output logic [4:0]                    rf_waddr,
    output logic [XLEN-1:0]               rf_wdata,
    output logic                          wb_stall,
    output logic                          ld_misalign,
    output logic                          ld_unexp
);
    localparam int SELW = $clog2(NUM_SRC);
    localparam int OFFW = $clog2(XLEN/8);
    localparam logic [SELW-1:0] LD_SEL = SELW'(LD_SRC);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT_LD = 2'd1, DRAIN = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [4:0]        rd_q, rd_d;
    logic              rw_q, rw_d;
    logic [2:0]        f3_q, f3_d;
    logic [OFFW-1:0]   off_q, off_d;
    logic              rf_we_q, rf_we_d;
    logic [4:0]        waddr_q, waddr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              mis_q, mis_d;
    logic              unexp_q, unexp_d;

    logic              accept, is_ld;
    logic [XLEN-1:0]   src_data;
    logic [2:0]        ex_f3;
    logic [OFFW-1:0]   ex_off;
    logic [XLEN-1:0]   ex_sh, ex_data;
    logic              ex_msb, ex_err;
    int                ex_bits;
    logic              commit, c_load, c_rw;
    logic [4:0]        c_rd;
    logic [XLEN-1:0]   c_data;

    assign w_ready  = (state_q == IDLE) && !w_flush;
    assign accept   = w_valid && w_ready;
    assign is_ld    = (w_wb_sel == LD_SEL);
    assign wb_stall = (state_q != IDLE) || (accept && is_ld && !ld_rvalid);

    // Out-of-range selects fall through to slot 0.
    always_comb begin
        src_data = w_src_data[XLEN-1:0];
        for (int i = 1; i < NUM_SRC; i++) begin
            if (int'(w_wb_sel) == i) src_data = w_src_data[i*XLEN +: XLEN];
        end
    end

    // Same-cycle returns use the live MW fields, late returns the captured ones.
    assign ex_f3  = (state_q == IDLE) ? w_funct3 : f3_q;
    assign ex_off = (state_q == IDLE) ? w_addr_lo : off_q;
    assign ex_sh  = ld_rdata >> {ex_off, 3'b000};

    always_comb begin
        ex_bits = XLEN;
        ex_msb  = ex_sh[XLEN-1];
        ex_err  = 1'b0;
        case (ex_f3[1:0])
            2'b00: begin ex_bits = 8;  ex_msb = ex_sh[7];  end
            2'b01: begin ex_bits = 16; ex_msb = ex_sh[15]; ex_err = ex_off[0];      end
            2'b10: begin ex_bits = 32; ex_msb = ex_sh[31]; ex_err = |ex_off[1:0];   end
            default: ex_err = |ex_off;
        endcase
        if (ex_f3 == 3'b111 || (XLEN == 32 && (ex_f3 == 3'b011 || ex_f3 == 3'b110))) ex_err = 1'b1;
        ex_data = ex_sh;
        for (int i = 0; i < XLEN; i++) begin
            if (i >= ex_bits) ex_data[i] = ex_msb & !ex_f3[2];
        end
    end

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        rw_d    = rw_q;
        f3_d    = f3_q;
        off_d   = off_q;
        commit  = 1'b0;
        c_load  = 1'b0;
        c_rw    = 1'b0;
        c_rd    = 5'd0;
        c_data  = '0;
        unexp_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && !is_ld) begin
                    commit = 1'b1;
                    c_rw   = w_reg_write;
                    c_rd   = w_rd;
                    c_data = src_data;
                end else if (accept && ld_rvalid) begin
                    commit = 1'b1;
                    c_load = 1'b1;
                    c_rw   = w_reg_write;
                    c_rd   = w_rd;
                    c_data = ex_data;
                end else if (accept) begin
                    rd_d    = w_rd;
                    rw_d    = w_reg_write;
                    f3_d    = w_funct3;
                    off_d   = w_addr_lo;
                    state_d = WAIT_LD;
                end
                unexp_d = ld_rvalid && !(accept && is_ld);
            end
            WAIT_LD: begin
                if (ld_rvalid) begin
                    state_d = IDLE;
                    if (!w_flush) begin
                        commit = 1'b1;
                        c_load = 1'b1;
                        c_rw   = rw_q;
                        c_rd   = rd_q;
                        c_data = ex_data;
                    end
                end else if (w_flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (ld_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        mis_d   = c_load && ex_err;
        rf_we_d = commit && c_rw && (c_rd != 5'd0) && !mis_d;
        waddr_d = commit ? c_rd : waddr_q;
        wdata_d = commit ? c_data : wdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rd_q    <= 5'd0;
            rw_q    <= 1'b0;
            f3_q    <= 3'd0;
            off_q   <= '0;
            rf_we_q <= 1'b0;
            waddr_q <= 5'd0;
            wdata_q <= '0;
            mis_q   <= 1'b0;
            unexp_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            rw_q    <= rw_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            rf_we_q <= rf_we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            mis_q   <= mis_d;
            unexp_q <= unexp_d;
        end
    end

    assign rf_we       = rf_we_q;
    assign rf_waddr    = waddr_q;
    assign rf_wdata    = wdata_q;
    assign ld_misalign = mis_q;
    assign ld_unexp    = unexp_q;
endmodule

// File: tb/tb_wb_commit_unit.sv
// tb/tb_wb_commit_unit.sv - self-checking bench for wb_commit_unit (XLEN=32, NUM_SRC=4)
module tb_wb_commit_unit;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         w_valid, w_flush, w_reg_write, ld_rvalid;
    logic [4:0]   w_rd;
    logic [1:0]   w_wb_sel, w_addr_lo;
    logic [2:0]   w_funct3;
    logic [127:0] w_src_data;
    logic [31:0]  ld_rdata;
    logic         w_ready, rf_we, wb_stall, ld_misalign, ld_unexp;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    wb_commit_unit #(.XLEN(32), .NUM_SRC(4), .LD_SRC(1)) dut (
        .clk(clk), .rst_n(rst_n), .w_valid(w_valid), .w_ready(w_ready), .w_flush(w_flush),
        .w_reg_write(w_reg_write), .w_rd(w_rd), .w_wb_sel(w_wb_sel), .w_funct3(w_funct3),
        .w_addr_lo(w_addr_lo), .w_src_data(w_src_data), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_stall(wb_stall),
        .ld_misalign(ld_misalign), .ld_unexp(ld_unexp)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: a queue of outstanding loads plus a drain flag.
    typedef struct {
        logic       rw;
        logic [4:0] rd;
        logic [2:0] f3;
        logic [1:0] off;
    } ld_t;

    ld_t         pend[$];
    ld_t         m_ld;
    bit          draining = 0;
    bit          m_busy, m_acc, m_acc_ld, m_ready, m_stall;
    logic        e_we = 0, e_mis = 0, e_unexp = 0;
    logic [4:0]  e_waddr = 0;
    logic [31:0] e_wdata = 0;

    function automatic logic [31:0] ld_val(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] d);
        int          sz;
        logic [63:0] m, v;
        sz = 1 << f3[1:0];
        m  = (64'd1 << (8 * sz)) - 64'd1;
        v  = ({32'd0, d} >> (8 * int'(off))) & m;
        if (!f3[2] && v[8 * sz - 1]) v = v | ~m;
        return v[31:0];
    endfunction

    function automatic bit ld_bad(input logic [2:0] f3, input logic [1:0] off);
        int sz;
        sz = 1 << f3[1:0];
        return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || ((int'(off) % sz) != 0);
    endfunction

    task automatic m_commit(input logic rw, input logic [4:0] rd, input logic [31:0] data, input bit bad);
        e_mis   = bad;
        e_we    = rw && (rd != 5'd0) && !bad;
        e_waddr = rd;
        e_wdata = data;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            pend.delete();
            draining = 0;
            e_we = 0; e_mis = 0; e_unexp = 0; e_waddr = 0; e_wdata = 0;
            chk("rst_we", 64'(rf_we), 64'd0);
            chk("rst_waddr", 64'(rf_waddr), 64'd0);
            chk("rst_wdata", 64'(rf_wdata), 64'd0);
            chk("rst_mis", 64'(ld_misalign), 64'd0);
            chk("rst_unexp", 64'(ld_unexp), 64'd0);
            chk("rst_stall", 64'(wb_stall), 64'd0);
        end else begin
            m_busy   = (pend.size() != 0) || draining;
            m_ready  = !m_busy && !w_flush;
            m_acc    = w_valid && m_ready;
            m_acc_ld = m_acc && (w_wb_sel == 2'd1);
            m_stall  = m_busy || (m_acc_ld && !ld_rvalid);
            chk("m_ready", 64'(w_ready), 64'(m_ready));
            chk("m_stall", 64'(wb_stall), 64'(m_stall));
            chk("m_we", 64'(rf_we), 64'(e_we));
            chk("m_waddr", 64'(rf_waddr), 64'(e_waddr));
            chk("m_wdata", 64'(rf_wdata), 64'(e_wdata));
            chk("m_mis", 64'(ld_misalign), 64'(e_mis));
            chk("m_unexp", 64'(ld_unexp), 64'(e_unexp));
            e_we = 0; e_mis = 0; e_unexp = 0;
            if (!m_busy) begin
                if (m_acc && !m_acc_ld)
                    m_commit(w_reg_write, w_rd, w_src_data[32*int'(w_wb_sel) +: 32], 0);
                else if (m_acc_ld && ld_rvalid)
                    m_commit(w_reg_write, w_rd, ld_val(w_funct3, w_addr_lo, ld_rdata), ld_bad(w_funct3, w_addr_lo));
                else if (m_acc_ld)
                    pend.push_back('{rw: w_reg_write, rd: w_rd, f3: w_funct3, off: w_addr_lo});
                if (ld_rvalid && !m_acc_ld) e_unexp = 1;
            end else if (draining) begin
                if (ld_rvalid) draining = 0;
            end else if (ld_rvalid) begin
                m_ld = pend.pop_front();
                if (!w_flush) m_commit(m_ld.rw, m_ld.rd, ld_val(m_ld.f3, m_ld.off, ld_rdata), ld_bad(m_ld.f3, m_ld.off));
            end else if (w_flush) begin
                void'(pend.pop_front());
                draining = 1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input bit v, input bit fl, input bit rw, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [1:0] off, input bit rv, input logic [31:0] rdat);
        w_valid = v; w_flush = fl; w_reg_write = rw; w_rd = rd; w_wb_sel = sel;
        w_funct3 = f3; w_addr_lo = off; ld_rvalid = rv; ld_rdata = rdat;
    endtask

    task automatic idle();
        put(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 1'b0, 32'd0);
    endtask

    logic [2:0]  vf3  [0:7] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2, 3'd1, 3'd3, 3'd6};
    logic [1:0]  voff [0:7] = '{2'd3, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd0, 2'd0};
    logic [31:0] vdat [0:7] = '{32'h8100_0000, 32'h0000_F000, 32'h0000_7FFF, 32'h8001_0000,
                                32'hCAFE_F00D, 32'h1234_5678, 32'h0BAD_0BAD, 32'h7654_3210};
    int          vdly [0:7] = '{0, 1, 2, 0, 1, 1, 0, 2};
    logic [31:0] vexp [0:7] = '{32'hFFFF_FF81, 32'h0000_00F0, 32'h0000_7FFF, 32'h0000_8001,
                                32'hCAFE_F00D, 32'h0, 32'h0, 32'h0};
    bit          vmis [0:7] = '{0, 0, 0, 0, 0, 1, 1, 1};

    initial begin
        w_src_data = {32'hC5C5_0003, 32'h0000_1004, 32'hDEAD_BEEF, 32'h1234_5678};
        idle();
        rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;

        cyc();
        put(1'b1, 1'b0, 1'b1, 5'd5, 2'd0, 3'd0, 2'd0, 1'b0, 32'd0);
        cyc();
        chk("alu_we", 64'(rf_we), 64'd1);
        chk("alu_waddr", 64'(rf_waddr), 64'd5);
        chk("alu_wdata", 64'(rf_wdata), 64'h1234_5678);

        put(1'b1, 1'b0, 1'b1, 5'd6, 2'd1, 3'd0, 2'd2, 1'b1, 32'h0080_0000);
        cyc();
        chk("lb_we", 64'(rf_we), 64'd1);
        chk("lb_wdata", 64'(rf_wdata), 64'hFFFF_FF80);
        put(1'b1, 1'b0, 1'b1, 5'd6, 2'd1, 3'd4, 2'd2, 1'b1, 32'h0080_0000);
        cyc();
        chk("lbu_wdata", 64'(rf_wdata), 64'h0000_0080);

        put(1'b1, 1'b0, 1'b1, 5'd7, 2'd1, 3'd1, 2'd2, 1'b0, 32'd0);
        #1 chk("lh_acc_stall", 64'(wb_stall), 64'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            put(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, i == 2, 32'hBEEF_1234);
            #1;
            chk("lh_wait_ready", 64'(w_ready), 64'd0);
            chk("lh_wait_stall", 64'(wb_stall), 64'd1);
            chk("lh_wait_we", 64'(rf_we), 64'd0);
        end
        cyc();
        chk("lh_we", 64'(rf_we), 64'd1);
        chk("lh_waddr", 64'(rf_waddr), 64'd7);
        chk("lh_wdata", 64'(rf_wdata), 64'hFFFF_BEEF);
        put(1'b1, 1'b0, 1'b1, 5'd8, 2'd2, 3'd0, 2'd0, 1'b0, 32'd0);
        #1 chk("b2b_ready", 64'(w_ready), 64'd1);
        cyc();
        chk("b2b_waddr", 64'(rf_waddr), 64'd8);
        chk("b2b_wdata", 64'(rf_wdata), 64'h0000_1004);

        put(1'b1, 1'b0, 1'b1, 5'd9, 2'd1, 3'd2, 2'd1, 1'b1, 32'h1111_2222);
        cyc();
        chk("lw_mis_pulse", 64'(ld_misalign), 64'd1);
        chk("lw_mis_we", 64'(rf_we), 64'd0);
        idle();
        #1;
        chk("lw_mis_ready", 64'(w_ready), 64'd1);
        chk("lw_mis_stall", 64'(wb_stall), 64'd0);
        cyc();
        chk("lw_mis_clear", 64'(ld_misalign), 64'd0);

        put(1'b1, 1'b0, 1'b1, 5'd10, 2'd1, 3'd2, 2'd0, 1'b0, 32'd0);
        cyc();
        put(1'b0, 1'b1, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 1'b0, 32'd0);
        #1 chk("fl_ready", 64'(w_ready), 64'd0);
        cyc();
        idle();
        #1 chk("drain_stall", 64'(wb_stall), 64'd1);
        cyc();
        put(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 1'b1, 32'h5555_AAAA);
        #1 chk("drain_rv_ready", 64'(w_ready), 64'd0);
        cyc();
        chk("drain_we", 64'(rf_we), 64'd0);
        chk("drain_unexp", 64'(ld_unexp), 64'd0);
        idle();
        #1 chk("drain_ready", 64'(w_ready), 64'd1);

        put(1'b1, 1'b0, 1'b1, 5'd0, 2'd3, 3'd0, 2'd0, 1'b0, 32'd0);
        cyc();
        chk("rd0_we", 64'(rf_we), 64'd0);
        put(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 1'b1, 32'h7777_7777);
        cyc();
        idle();
        chk("unexp_pulse", 64'(ld_unexp), 64'd1);
        chk("unexp_we", 64'(rf_we), 64'd0);
        cyc();
        chk("unexp_clear", 64'(ld_unexp), 64'd0);

        put(1'b1, 1'b1, 1'b1, 5'd11, 2'd0, 3'd0, 2'd0, 1'b0, 32'd0);
        #1 chk("idle_flush_ready", 64'(w_ready), 64'd0);
        cyc();
        chk("idle_flush_we", 64'(rf_we), 64'd0);
        put(1'b1, 1'b0, 1'b1, 5'd12, 2'd1, 3'd0, 2'd0, 1'b0, 32'd0);
        cyc();
        put(1'b0, 1'b1, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 1'b1, 32'h0000_00FF);
        cyc();
        idle();
        chk("flrv_we", 64'(rf_we), 64'd0);
        #1 chk("flrv_ready", 64'(w_ready), 64'd1);

        for (int k = 0; k < 8; k++) begin
            cyc();
            put(1'b1, 1'b0, 1'b1, 5'(13 + k), 2'd1, vf3[k], voff[k], vdly[k] == 0, vdat[k]);
            for (int j = 0; j < vdly[k]; j++) begin
                cyc();
                put(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, j == vdly[k] - 1, vdat[k]);
            end
            cyc();
            idle();
            chk("tbl_mis", 64'(ld_misalign), 64'(vmis[k]));
            chk("tbl_we", 64'(rf_we), 64'(!vmis[k]));
            if (!vmis[k]) chk("tbl_wdata", 64'(rf_wdata), 64'(vexp[k]));
        end

        cyc();
        put(1'b1, 1'b0, 1'b1, 5'd20, 2'd1, 3'd2, 2'd0, 1'b0, 32'd0);
        cyc();
        idle();
        #1 chk("rstw_stall", 64'(wb_stall), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rstw_we", 64'(rf_we), 64'd0);
        chk("rstw_waddr", 64'(rf_waddr), 64'd0);
        chk("rstw_wdata", 64'(rf_wdata), 64'd0);
        chk("rstw_stall0", 64'(wb_stall), 64'd0);
        chk("rstw_ready", 64'(w_ready), 64'd1);
        cyc();
        rst_n = 1'b1;
        cyc();
        put(1'b1, 1'b0, 1'b1, 5'd31, 2'd3, 3'd0, 2'd0, 1'b0, 32'd0);
        cyc();
        idle();
        chk("post_rst_waddr", 64'(rf_waddr), 64'd31);
        chk("post_rst_wdata", 64'(rf_wdata), 64'hC5C5_0003);
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
